layer_compositor: RTL and testbench
===================================

# layer_compositor

Parametrised pixel compositor for the VGA path. It takes per-pixel hit flags and colour indices from up to `NUM_LAYERS` sprite/tile layers and picks the highest-priority opaque layer. It resolves the winning index through one shared, runtime-writable palette RAM and applies a frame-synchronous global fade before driving VGA RGB. It sits between the layer generators and the VGA controller, replacing the fixed per-sprite colour mapping.

## Interface
- `NUM_LAYERS`, 8: number of layers; layer 0 has the highest priority.
- `IDX_W`, 6: per-layer colour-index width; must be ≤ 8.
- `PAL_AW`, 8: palette address width; must be ≤ 16. The palette holds 2^PAL_AW entries of 24 bits.
- `FADE_DIV`, 2: number of `frame_start` pulses per fade level step; must be ≥ 1.
- `Clk` in 1: pixel clock.
- `Reset_n` in 1: reset. One clock; reset is synchronous and active-low.
- `pix_valid` in 1: the pixel inputs are valid this cycle.
- `DrawX`, `DrawY` in 10 each: current pixel coordinates.
- `layer_hit` in NUM_LAYERS: bit i means layer i covers this pixel.
- `layer_idx` in NUM_LAYERS*IDX_W: colour index of layer i, held in bits [i*IDX_W +: IDX_W].
- `cfg_we` in 1: configuration write strobe.
- `cfg_addr` in PAL_AW+1: with MSB=0 the low bits select a palette entry; with MSB=1 the low bits select a layer register (values ≥ NUM_LAYERS are ignored).
- `cfg_data` in 24: for a palette write, the data is {R,G,B}. For a layer write: [PAL_AW-1:0] is the base, [16 +: 8] is the key (low IDX_W bits are used), and [23] is key_en.
- `frame_start` in 1: one-cycle pulse at the start of vertical blank.
- `fade_out_req`, `fade_in_req` in 1 each: single-cycle requests.
- `VGA_R`, `VGA_G`, `VGA_B` out 8 each: composited colour.
- `out_valid` out 1: `pix_valid` delayed by 4 cycles.
- `fade_busy` out 1: high in the FADE_OUT and FADE_IN states.

## Operation
- **Opaque test:** layer i is opaque when `layer_hit[i]` is set AND NOT (key_en_i AND idx_i == key_i).
- **Winner:** the winner is the lowest-numbered opaque layer.
- **Palette address:** (base_i + idx_i) mod 2^PAL_AW. The index is zero-extended before the add.
- **No opaque layer (background):** B = 8'h7F − {1'b0, DrawX[9:3]}.
  - DrawY < 31 gives R=F0, G=80, B=00.
  - DrawY = 31 or 32 gives R=90, G=0F, B=00.
  - Otherwise R=10, G=78.
- **Fade scaling:** each channel out = (c × level) >> 5. `level` is 6 bits, range 0..32, so level 32 is passthrough.
- **Fade FSM states:** SHOW (level 32), FADE_OUT, DARK (level 0), FADE_IN.
  - SHOW + fade_out_req → FADE_OUT.
  - DARK + fade_in_req → FADE_IN.
  - FADE_OUT + fade_in_req → FADE_IN (reverses from the current level).
  - FADE_IN + fade_out_req → FADE_OUT.
  - Both requests in the same cycle: fade_out_req wins.
  - Requests that are invalid for the current state are dropped.
- **Fade stepping:** a frame counter (0..FADE_DIV−1) advances on `frame_start` only while fading. It resets to 0 on every state change.
  - When the counter wraps, level decrements (in FADE_OUT) or increments (in FADE_IN).
  - Level reaching 0 → DARK; level reaching 32 → SHOW, both on that same edge.
  - Level never changes mid-frame.
- **Layer registers:** a write affects pixels entering stage 2 on the following cycle.
- **Palette read/write collision:** a palette write and a read of the same address in the same cycle return the old data (read-before-write).

## Timing
- **Pipeline:**
  - S1 registers the inputs.
  - S2 runs the priority/key test, computes the address, and computes the background colour.
  - S3 does the synchronous palette read, with the winner/background select carried alongside.
  - S4 applies the fade multiply and registers the outputs.
- **Latency:** fixed at 4 cycles, throughput 1 pixel/cycle, no stalls.
- **`pix_valid` = 0:** the pipeline still advances, `out_valid` is 0, and the RGB value is don't-care (the bench ignores it).
- **Reset, applied on the clock edge:**
  - All outputs become 0 and all stage valids are cleared.
  - FSM goes to SHOW, level 32, frame counter 0.
  - Every layer register becomes base=0, key=0, key_en=1.
  - Palette RAM is not reset.
- **Reset mid-fade:** returns to SHOW at full brightness.

## Structure
- The shared package `compositor_pkg` holds the `fade_state_t` enum, the background constants (F0/80/00, 90/0F/00, 10/78/7F, the 31/32 row limits), and `LEVEL_MAX` = 32.
- One sub-module, `palette_ram`: single-port write, single-port synchronous read, 24-bit, parametrised by PAL_AW, inferring block RAM.
- The priority encoder and fade FSM are inline.

## Test plan
- **Priority with key:** write layer 0 {key=0, key_en=1} and layer 3 {base=16}; palette[21]=123456. Drive layer_hit=0b1001, idx0=0, idx3=5 → 4 cycles later RGB=12/34/56, out_valid=1.
- **Key disabled:** repeat the previous scenario with layer 0 {key_en=0, base=0} and palette[0]=FF0000 → RGB=FF/00/00.
- **Background:** layer_hit=0 at DrawY=10 → F0/80/00; at DrawY=32 → 90/0F/00; at DrawY=100, DrawX=80 → 10/78/75.
- **Fade:** with FADE_DIV=2, palette colour 404040. Pulse fade_out_req, then 2 frame_starts → level 31, RGB=3E/3E/3E. After 64 frame_starts → DARK, RGB 0, fade_busy=0.
- **Reversal and simultaneous requests:**
  - In FADE_OUT at level 20, fade_in_req → level climbs to 32 and reaches SHOW after 24 frame_starts.
  - Asserting both requests in SHOW → FADE_OUT.
- **Wrap and collision:**
  - base=250, idx=10 reads palette[4].
  - A same-cycle palette write and read of address 4 returns the old value; the next pixel returns the new value.
  - Reset_n low mid-fade → level 32 and out_valid=0 on the following cycle.

Source files
------------

// File: rtl/compositor_pkg.sv
// Shared types and constants for the layer compositor: fade FSM states,
// background colour bands and the full-brightness fade level.
package compositor_pkg;

    typedef enum logic [1:0] {
        ST_SHOW,
        ST_FADE_OUT,
        ST_DARK,
        ST_FADE_IN
    } fade_state_t;

    localparam int PAL_DW = 24;

    localparam logic [7:0] BG_TOP_R      = 8'hF0;
    localparam logic [7:0] BG_TOP_G      = 8'h80;
    localparam logic [7:0] BG_TOP_B      = 8'h00;
    localparam logic [7:0] BG_BAND_R     = 8'h90;
    localparam logic [7:0] BG_BAND_G     = 8'h0F;
    localparam logic [7:0] BG_BAND_B     = 8'h00;
    localparam logic [7:0] BG_LOW_R      = 8'h10;
    localparam logic [7:0] BG_LOW_G      = 8'h78;
    localparam logic [7:0] BG_LOW_B_BASE = 8'h7F;

    localparam logic [9:0] BG_ROW_TOP      = 10'd31;
    localparam logic [9:0] BG_ROW_BAND_END = 10'd32;

    localparam logic [5:0] LEVEL_MAX = 6'd32;

endpackage

// File: rtl/palette_ram.sv
// Shared colour palette: one write port, one synchronous read port.
// A same-address write and read in one cycle returns the old entry.
module palette_ram
    import compositor_pkg::*;
#(
    parameter int PAL_AW = 8
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [PAL_AW-1:0] i_waddr,
    input  logic [PAL_DW-1:0] i_wdata,
    input  logic [PAL_AW-1:0] i_raddr,
    output logic [PAL_DW-1:0] o_rdata
);

    logic [PAL_DW-1:0] r_mem [2**PAL_AW];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/layer_compositor.sv
// Four-stage pixel compositor: keyed priority select across layers, shared
// palette lookup or procedural background, then a frame-synchronous fade.
module layer_compositor
    import compositor_pkg::*;
#(
    parameter int NUM_LAYERS = 8,
    parameter int IDX_W      = 6,
    parameter int PAL_AW     = 8,
    parameter int FADE_DIV   = 2
) (
    input  logic                        i_Clk,
    input  logic                        i_Reset_n,
    input  logic                        i_pix_valid,
    input  logic [9:0]                  i_DrawX,
    input  logic [9:0]                  i_DrawY,
    input  logic [NUM_LAYERS-1:0]       i_layer_hit,
    input  logic [NUM_LAYERS*IDX_W-1:0] i_layer_idx,
    input  logic                        i_cfg_we,
    input  logic [PAL_AW:0]             i_cfg_addr,
    input  logic [23:0]                 i_cfg_data,
    input  logic                        i_frame_start,
    input  logic                        i_fade_out_req,
    input  logic                        i_fade_in_req,
    output logic [7:0]                  o_VGA_R,
    output logic [7:0]                  o_VGA_G,
    output logic [7:0]                  o_VGA_B,
    output logic                        o_out_valid,
    output logic                        o_fade_busy
);

    localparam int CNT_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FADE_DIV - 1);

    function automatic logic [7:0] fade_scale(input logic [7:0] c, input logic [5:0] lvl);
        logic [13:0] prod;
        prod = {6'b0, c} * {8'b0, lvl};
        return 8'(prod >> 5);
    endfunction

    function automatic logic [23:0] bg_colour(input logic [6:0] xs, input logic [9:0] y);
        if (y < BG_ROW_TOP)
            return {BG_TOP_R, BG_TOP_G, BG_TOP_B};
        else if (y <= BG_ROW_BAND_END)
            return {BG_BAND_R, BG_BAND_G, BG_BAND_B};
        else
            return {BG_LOW_R, BG_LOW_G, BG_LOW_B_BASE - {1'b0, xs}};
    endfunction

    logic w_unused;
    assign w_unused = ^{i_DrawX[2:0], i_cfg_data};

    logic w_pal_we, w_layer_we;
    assign w_pal_we   = i_cfg_we && !i_cfg_addr[PAL_AW];
    assign w_layer_we = i_cfg_we &&  i_cfg_addr[PAL_AW];

    logic [PAL_AW-1:0]     r_base [NUM_LAYERS];
    logic [IDX_W-1:0]      r_key  [NUM_LAYERS];
    logic [NUM_LAYERS-1:0] r_key_en;

    // Out-of-range layer addresses match no slot and are dropped.
    always_ff @(posedge i_Clk) begin
        if (!i_Reset_n) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                r_base[i] <= '0;
                r_key[i]  <= '0;
            end
            r_key_en <= '1;
        end else if (w_layer_we) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                if (i_cfg_addr[PAL_AW-1:0] == PAL_AW'(i)) begin
                    r_base[i]   <= i_cfg_data[PAL_AW-1:0];
                    r_key[i]    <= i_cfg_data[16 +: IDX_W];
                    r_key_en[i] <= i_cfg_data[23];
                end
            end
        end
    end

    // ---- stage 1: input register ----
    logic                        r_vld_p1;
    logic [NUM_LAYERS-1:0]       r_hit_p1;
    logic [NUM_LAYERS*IDX_W-1:0] r_idx_p1;
    logic [6:0]                  r_x_p1;
    logic [9:0]                  r_y_p1;

    always_ff @(posedge i_Clk) begin
        if (!i_Reset_n) r_vld_p1 <= 1'b0;
        else            r_vld_p1 <= i_pix_valid;
    end

    always_ff @(posedge i_Clk) begin
        r_hit_p1 <= i_layer_hit;
        r_idx_p1 <= i_layer_idx;
        r_x_p1   <= i_DrawX[9:3];
        r_y_p1   <= i_DrawY;
    end

    // ---- stage 2: priority/key select, palette address, background ----
    logic              w_win;
    logic [PAL_AW-1:0] w_addr;

    always_comb begin
        w_win  = 1'b0;
        w_addr = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (r_hit_p1[i] && !(r_key_en[i] && (r_idx_p1[i*IDX_W +: IDX_W] == r_key[i]))) begin
                w_win  = 1'b1;
                w_addr = r_base[i] + PAL_AW'(r_idx_p1[i*IDX_W +: IDX_W]);
            end
        end
    end

    logic              r_vld_p2, r_win_p2;
    logic [PAL_AW-1:0] r_addr_p2;
    logic [23:0]       r_bg_p2;

    always_ff @(posedge i_Clk) begin
        if (!i_Reset_n) r_vld_p2 <= 1'b0;
        else            r_vld_p2 <= r_vld_p1;
    end

    always_ff @(posedge i_Clk) begin
        r_win_p2  <= w_win;
        r_addr_p2 <= w_addr;
        r_bg_p2   <= bg_colour(r_x_p1, r_y_p1);
    end

    // ---- stage 3: palette read, select flag and background carried alongside ----
    logic [23:0] w_pal_rdata;

    palette_ram #(.PAL_AW(PAL_AW)) u_palette (
        .i_clk   (i_Clk),
        .i_we    (w_pal_we),
        .i_waddr (i_cfg_addr[PAL_AW-1:0]),
        .i_wdata (i_cfg_data),
        .i_raddr (r_addr_p2),
        .o_rdata (w_pal_rdata)
    );

    logic        r_vld_p3, r_win_p3;
    logic [23:0] r_bg_p3;

    always_ff @(posedge i_Clk) begin
        if (!i_Reset_n) r_vld_p3 <= 1'b0;
        else            r_vld_p3 <= r_vld_p2;
    end

    always_ff @(posedge i_Clk) begin
        r_win_p3 <= r_win_p2;
        r_bg_p3  <= r_bg_p2;
    end

    // ---- stage 4: fade multiply and output register ----
    fade_state_t      r_state, w_state_n;
    logic [5:0]       r_level, w_level_n;
    logic [CNT_W-1:0] r_cnt,   w_cnt_n;

    logic [23:0] w_col_p3;
    assign w_col_p3 = r_win_p3 ? w_pal_rdata : r_bg_p3;

    always_ff @(posedge i_Clk) begin
        if (!i_Reset_n) begin
            o_out_valid <= 1'b0;
            o_VGA_R     <= '0;
            o_VGA_G     <= '0;
            o_VGA_B     <= '0;
        end else begin
            o_out_valid <= r_vld_p3;
            o_VGA_R     <= fade_scale(w_col_p3[23:16], r_level);
            o_VGA_G     <= fade_scale(w_col_p3[15:8],  r_level);
            o_VGA_B     <= fade_scale(w_col_p3[7:0],   r_level);
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Reset_n) begin
            r_state <= ST_SHOW;
            r_level <= LEVEL_MAX;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_n;
            r_level <= w_level_n;
            r_cnt   <= w_cnt_n;
        end
    end

    // A reversal request takes precedence over a frame step in the same cycle.
    always_comb begin
        w_state_n = r_state;
        w_level_n = r_level;
        w_cnt_n   = r_cnt;
        case (r_state)
            ST_SHOW: begin
                if (i_fade_out_req) begin
                    w_state_n = ST_FADE_OUT;
                    w_cnt_n   = '0;
                end
            end
            ST_DARK: begin
                if (i_fade_in_req) begin
                    w_state_n = ST_FADE_IN;
                    w_cnt_n   = '0;
                end
            end
            ST_FADE_OUT: begin
                if (i_fade_in_req && !i_fade_out_req) begin
                    w_state_n = ST_FADE_IN;
                    w_cnt_n   = '0;
                end else if (i_frame_start) begin
                    if (r_cnt == CNT_LAST) begin
                        w_cnt_n   = '0;
                        w_level_n = (r_level == 6'd0) ? 6'd0 : r_level - 6'd1;
                        if (w_level_n == 6'd0) w_state_n = ST_DARK;
                    end else begin
                        w_cnt_n = r_cnt + CNT_W'(1);
                    end
                end
            end
            ST_FADE_IN: begin
                if (i_fade_out_req) begin
                    w_state_n = ST_FADE_OUT;
                    w_cnt_n   = '0;
                end else if (i_frame_start) begin
                    if (r_cnt == CNT_LAST) begin
                        w_cnt_n   = '0;
                        w_level_n = (r_level >= LEVEL_MAX) ? LEVEL_MAX : r_level + 6'd1;
                        if (w_level_n == LEVEL_MAX) w_state_n = ST_SHOW;
                    end else begin
                        w_cnt_n = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: w_state_n = ST_SHOW;
        endcase
    end

    assign o_fade_busy = (r_state == ST_FADE_OUT) || (r_state == ST_FADE_IN);

endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor: priority/keying, background bands,
// palette wrap and collision, fade stepping, reversal and reset.
module tb_layer_compositor;

    logic        clk = 1'b0;
    logic        Reset_n;
    logic        pix_valid;
    logic [9:0]  DrawX, DrawY;
    logic [7:0]  layer_hit;
    logic [47:0] layer_idx;
    logic        cfg_we;
    logic [8:0]  cfg_addr;
    logic [23:0] cfg_data;
    logic        frame_start, fade_out_req, fade_in_req;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        out_valid, fade_busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    layer_compositor dut (
        .i_Clk          (clk),
        .i_Reset_n      (Reset_n),
        .i_pix_valid    (pix_valid),
        .i_DrawX        (DrawX),
        .i_DrawY        (DrawY),
        .i_layer_hit    (layer_hit),
        .i_layer_idx    (layer_idx),
        .i_cfg_we       (cfg_we),
        .i_cfg_addr     (cfg_addr),
        .i_cfg_data     (cfg_data),
        .i_frame_start  (frame_start),
        .i_fade_out_req (fade_out_req),
        .i_fade_in_req  (fade_in_req),
        .o_VGA_R        (VGA_R),
        .o_VGA_G        (VGA_G),
        .o_VGA_B        (VGA_B),
        .o_out_valid    (out_valid),
        .o_fade_busy    (fade_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cfg(input logic [8:0] a, input logic [23:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    function automatic logic [47:0] mkidx(input logic [5:0] i0, input logic [5:0] i1, input logic [5:0] i3);
        logic [47:0] v;
        v = '0;
        v[0 +: 6]  = i0;
        v[6 +: 6]  = i1;
        v[18 +: 6] = i3;
        return v;
    endfunction

    // One pixel in, expect it exactly four cycles later.
    task automatic pix(input string tag, input logic [7:0] hit, input logic [47:0] idx,
                       input logic [9:0] x, input logic [9:0] y, input logic [23:0] exp);
        pix_valid = 1'b1; layer_hit = hit; layer_idx = idx; DrawX = x; DrawY = y;
        tick();
        pix_valid = 1'b0;
        tick();
        tick();
        chk({tag, "_vld_early"}, {31'b0, out_valid}, 32'd0);
        tick();
        chk({tag, "_vld"}, {31'b0, out_valid}, 32'd1);
        chk({tag, "_rgb"}, {8'b0, VGA_R, VGA_G, VGA_B}, {8'b0, exp});
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            tick();
        end
    endtask

    task automatic req(input logic o, input logic i);
        fade_out_req = o; fade_in_req = i;
        tick();
        fade_out_req = 1'b0; fade_in_req = 1'b0;
    endtask

    initial begin
        Reset_n = 1'b0; pix_valid = 1'b0; DrawX = '0; DrawY = '0;
        layer_hit = '0; layer_idx = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        frame_start = 1'b0; fade_out_req = 1'b0; fade_in_req = 1'b0;
        tick();
        tick();
        chk("rst_rgb",   {8'b0, VGA_R, VGA_G, VGA_B}, 32'd0);
        chk("rst_vld",   {31'b0, out_valid}, 32'd0);
        chk("rst_busy",  {31'b0, fade_busy}, 32'd0);
        Reset_n = 1'b1;
        tick();

        // Layer 0 keyed out, layer 3 wins at base 16 + idx 5
        cfg(9'h100, 24'h800000);
        cfg(9'h103, 24'h000010);
        cfg(9'h015, 24'h123456);
        pix("prio_key", 8'b0000_1001, mkidx(6'd0, 6'd0, 6'd5), 10'd0, 10'd200, 24'h123456);

        // Key disabled: layer 0 now opaque
        cfg(9'h100, 24'h000000);
        cfg(9'h000, 24'hFF0000);
        pix("key_off", 8'b0000_1001, mkidx(6'd0, 6'd0, 6'd5), 10'd0, 10'd200, 24'hFF0000);

        // Out-of-range layer write is ignored
        cfg(9'h108, 24'h800000);
        pix("bad_layer", 8'b0000_0001, mkidx(6'd0, 6'd0, 6'd0), 10'd0, 10'd200, 24'hFF0000);

        // Background bands
        pix("bg_y10",  8'h00, '0, 10'd0,  10'd10,  24'hF08000);
        pix("bg_y30",  8'h00, '0, 10'd0,  10'd30,  24'hF08000);
        pix("bg_y31",  8'h00, '0, 10'd0,  10'd31,  24'h900F00);
        pix("bg_y32",  8'h00, '0, 10'd0,  10'd32,  24'h900F00);
        pix("bg_y33",  8'h00, '0, 10'd0,  10'd33,  24'h10787F);
        pix("bg_x80",  8'h00, '0, 10'd80, 10'd100, 24'h107875);
        pix("bg_x1023",8'h00, '0, 10'd1023, 10'd100, 24'h107800);

        // Address wrap: base 250 + idx 10 -> entry 4
        cfg(9'h101, 24'h0000FA);
        cfg(9'h004, 24'hA1B2C3);
        pix("wrap", 8'b0000_0010, mkidx(6'd0, 6'd10, 6'd0), 10'd0, 10'd200, 24'hA1B2C3);

        // Collision: first pixel reads entry 4 on the same edge it is rewritten
        pix_valid = 1'b1; layer_hit = 8'b0000_0010; layer_idx = mkidx(6'd0, 6'd10, 6'd0);
        tick();
        tick();
        pix_valid = 1'b0;
        cfg_we = 1'b1; cfg_addr = 9'h004; cfg_data = 24'h0D0E0F;
        tick();
        cfg_we = 1'b0;
        tick();
        chk("coll_old_vld", {31'b0, out_valid}, 32'd1);
        chk("coll_old_rgb", {8'b0, VGA_R, VGA_G, VGA_B}, 32'h00A1B2C3);
        tick();
        chk("coll_new_vld", {31'b0, out_valid}, 32'd1);
        chk("coll_new_rgb", {8'b0, VGA_R, VGA_G, VGA_B}, 32'h000D0E0F);
        tick();

        // Fade out with FADE_DIV = 2
        cfg(9'h000, 24'h404040);
        frames(1);
        pix("show_full", 8'h01, '0, 10'd0, 10'd200, 24'h404040);
        req(1'b0, 1'b1);
        chk("drop_in_show", {31'b0, fade_busy}, 32'd0);
        req(1'b1, 1'b0);
        chk("fo_busy", {31'b0, fade_busy}, 32'd1);
        frames(1);
        pix("fo_1frame", 8'h01, '0, 10'd0, 10'd200, 24'h404040);
        frames(1);
        pix("fo_lvl31", 8'h01, '0, 10'd0, 10'd200, 24'h3E3E3E);
        frames(61);
        pix("fo_lvl1", 8'h01, '0, 10'd0, 10'd200, 24'h020202);
        chk("fo_lvl1_busy", {31'b0, fade_busy}, 32'd1);
        frames(1);
        pix("dark_rgb", 8'h01, '0, 10'd0, 10'd200, 24'h000000);
        chk("dark_busy", {31'b0, fade_busy}, 32'd0);

        // Fade in partway, then reset mid-fade
        req(1'b0, 1'b1);
        frames(10);
        pix("fi_lvl5", 8'h01, '0, 10'd0, 10'd200, 24'h0A0A0A);
        chk("fi_busy", {31'b0, fade_busy}, 32'd1);
        pix_valid = 1'b1; layer_hit = 8'h01; layer_idx = '0;
        tick();
        tick();
        Reset_n = 1'b0;
        tick();
        chk("midrst_vld",  {31'b0, out_valid}, 32'd0);
        chk("midrst_rgb",  {8'b0, VGA_R, VGA_G, VGA_B}, 32'd0);
        chk("midrst_busy", {31'b0, fade_busy}, 32'd0);
        Reset_n = 1'b1; pix_valid = 1'b0;
        tick();
        chk("postrst_vld", {31'b0, out_valid}, 32'd0);
        // Layer 0 back to key 0 / key_en 1, so idx 0 is transparent
        pix("rst_layer_bg", 8'h01, '0, 10'd0, 10'd100, 24'h10787F);
        cfg(9'h100, 24'h000000);
        pix("rst_full", 8'h01, '0, 10'd0, 10'd200, 24'h404040);

        // Reverse at level 20
        req(1'b1, 1'b0);
        frames(24);
        pix("rev_lvl20", 8'h01, '0, 10'd0, 10'd200, 24'h282828);
        req(1'b0, 1'b1);
        chk("rev_busy", {31'b0, fade_busy}, 32'd1);
        frames(23);
        pix("rev_lvl31", 8'h01, '0, 10'd0, 10'd200, 24'h3E3E3E);
        chk("rev_lvl31_busy", {31'b0, fade_busy}, 32'd1);
        frames(1);
        pix("rev_show", 8'h01, '0, 10'd0, 10'd200, 24'h404040);
        chk("rev_show_busy", {31'b0, fade_busy}, 32'd0);

        // Both requests in SHOW: fade-out wins; counter clears on reversal
        req(1'b1, 1'b1);
        chk("both_busy", {31'b0, fade_busy}, 32'd1);
        frames(1);
        req(1'b0, 1'b1);
        frames(1);
        chk("cnt_clr_busy", {31'b0, fade_busy}, 32'd1);
        frames(1);
        chk("fi_top_show", {31'b0, fade_busy}, 32'd0);
        pix("fi_top_rgb", 8'h01, '0, 10'd0, 10'd200, 24'h404040);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
